// File: rtl/relu_norm_unit.sv
// ReLU, Forward-Forward goodness and L2 normalisation of one layer.
// Collects pre-activations, takes isqrt of the sum of squares, divides per neuron.
module relu_norm_unit #(
  parameter int NUM_NEURONS = 256,
  parameter int DATA_WIDTH  = 32,
  parameter int FRAC_BITS   = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH-1:0]          in_data,
  output logic                           buf_clear,
  output logic                           buf_we,
  output logic [$clog2(NUM_NEURONS)-1:0] buf_waddr,
  output logic [DATA_WIDTH-1:0]          buf_wdata,
  output logic [DATA_WIDTH-1:0]          goodness,
  output logic                           goodness_valid,
  output logic                           busy,
  output logic                           done
);

  localparam int DW    = DATA_WIDTH;
  localparam int IW    = $clog2(NUM_NEURONS);
  localparam int ACC_W = 2 * DW + IW;
  localparam int RW    = (ACC_W + 1) / 2;
  localparam int SQW   = 2 * RW;
  localparam int RMW   = RW + 1;
  localparam int DVW   = DW + FRAC_BITS;
  localparam int CW    = $clog2(DVW + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_SQRT,
    S_DIVIDE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic [DW-1:0]    scratch [NUM_NEURONS];
  logic [ACC_W-1:0] acc;
  logic [SQW-1:0]   sq;
  logic [RMW-1:0]   srem;
  logic [RW-1:0]    root;
  logic [RW-1:0]    drem;
  logic [DVW-1:0]   dvd;
  logic [DVW-1:0]   quo;
  logic [DW-1:0]    q;

  logic             fire, last;
  logic             sqrt_end, div_end, norm_zero;
  logic [DW-1:0]    relu;
  logic [2*DW-1:0]  relu_w, prod;
  logic [ACC_W-1:0] acc_nx, acc_sh;
  logic [DW-1:0]    g_sat;
  logic [RMW+1:0]   srem_sh, trial;
  logic             sbit;
  logic [RMW-1:0]   srem_nx;
  logic [RW:0]      drem_sh, dsor;
  logic             dbit;
  logic [RW-1:0]    drem_nx;
  logic [DVW-1:0]   quo_nx;
  logic [DW-1:0]    q_sat;
  logic [IW-1:0]    idx_inc;

  always_comb begin
    fire      = (state == S_COLLECT) && in_valid;
    last      = idx == IW'(NUM_NEURONS - 1);
    sqrt_end  = cnt == CW'(RW - 1);
    div_end   = cnt == CW'(DVW - 1);
    norm_zero = root == '0;
    idx_inc   = idx + IW'(1);
    relu      = in_data[DW-1] ? '0 : in_data;
    relu_w    = (2 * DW)'(relu);
    prod      = relu_w * relu_w;
    acc_nx    = acc + ACC_W'(prod);
    acc_sh    = acc >> FRAC_BITS;
    g_sat     = (|acc_sh[ACC_W-1:DW]) ? '1 : acc_sh[DW-1:0];
  end

  // Restoring isqrt: trial subtrahend is 4*root+1 per bit pair.
  always_comb begin
    srem_sh = {srem, sq[SQW-1 -: 2]};
    trial   = {1'b0, root, 2'b01};
    sbit    = srem_sh >= trial;
    srem_nx = RMW'(sbit ? srem_sh - trial : srem_sh);
  end

  always_comb begin
    drem_sh = {drem, dvd[DVW-1]};
    dsor    = {1'b0, root};
    dbit    = drem_sh >= dsor;
    drem_nx = RW'(dbit ? drem_sh - dsor : drem_sh);
    quo_nx  = {quo[DVW-2:0], dbit};
    q_sat   = (|quo_nx[DVW-1:DW]) ? '1 : quo_nx[DW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (start) state_nx = S_COLLECT;
      S_COLLECT: if (fire && last) state_nx = S_SQRT;
      S_SQRT:    if (sqrt_end) state_nx = S_DIVIDE;
      S_DIVIDE:  if (norm_zero || div_end) state_nx = S_WRITE;
      S_WRITE:   state_nx = last ? S_DONE : S_DIVIDE;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx            <= '0;
      cnt            <= '0;
      acc            <= '0;
      sq             <= '0;
      srem           <= '0;
      root           <= '0;
      drem           <= '0;
      dvd            <= '0;
      quo            <= '0;
      q              <= '0;
      goodness       <= '0;
      goodness_valid <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++)
        scratch[i] <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            goodness_valid <= 1'b0;
            idx            <= '0;
            acc            <= '0;
            cnt            <= '0;
          end
        end
        S_COLLECT: begin
          if (fire) begin
            scratch[idx] <= relu;
            acc          <= acc_nx;
            idx          <= idx_inc;
            if (last) begin
              sq   <= SQW'(acc_nx);
              srem <= '0;
              root <= '0;
              cnt  <= '0;
            end
          end
        end
        S_SQRT: begin
          sq   <= sq << 2;
          srem <= srem_nx;
          root <= {root[RW-2:0], sbit};
          cnt  <= cnt + CW'(1);
          if (sqrt_end) begin
            goodness       <= g_sat;
            goodness_valid <= 1'b1;
            idx            <= '0;
            dvd            <= {scratch[0], {FRAC_BITS{1'b0}}};
            drem           <= '0;
            quo            <= '0;
            cnt            <= '0;
          end
        end
        S_DIVIDE: begin
          if (norm_zero) begin
            q <= '0;
          end else begin
            dvd  <= dvd << 1;
            drem <= drem_nx;
            quo  <= quo_nx;
            cnt  <= cnt + CW'(1);
            if (div_end) q <= q_sat;
          end
        end
        S_WRITE: begin
          if (!last) begin
            idx  <= idx_inc;
            dvd  <= {scratch[idx_inc], {FRAC_BITS{1'b0}}};
            drem <= '0;
            quo  <= '0;
            cnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = state == S_COLLECT;
    buf_clear = (state == S_IDLE) && start;
    buf_we    = state == S_WRITE;
    buf_waddr = idx;
    buf_wdata = q;
    done      = state == S_DONE;
    busy      = state != S_IDLE;
  end

endmodule

// File: tb/tb_relu_norm_unit.sv
// Scoreboard bench for relu_norm_unit at 4 neurons, Q16.16.
// Expected writes are queued at stimulus time and popped on buf_we.
module tb_relu_norm_unit;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          buf_clear;
  logic          buf_we;
  logic [IW-1:0] buf_waddr;
  logic [DW-1:0] buf_wdata;
  logic [DW-1:0] goodness;
  logic          goodness_valid;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  relu_norm_unit #(
    .NUM_NEURONS(N),
    .DATA_WIDTH (DW),
    .FRAC_BITS  (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .buf_clear     (buf_clear),
    .buf_we        (buf_we),
    .buf_waddr     (buf_waddr),
    .buf_wdata     (buf_wdata),
    .goodness      (goodness),
    .goodness_valid(goodness_valid),
    .busy          (busy),
    .done          (done)
  );

  typedef struct {
    logic [IW-1:0] addr;
    logic [DW-1:0] data;
    int            tol;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   n_we = 0;
  int   n_clr = 0;
  int   n_done = 0;

  logic [DW-1:0] d_basic [4];
  logic [DW-1:0] d_neg   [4];
  logic [DW-1:0] d_sat   [4];

  always @(negedge clk) begin : mon
    exp_t   e;
    longint dd;
    if (rst_n) begin
      if (buf_clear) n_clr++;
      if (done) n_done++;
      if (buf_we || buf_clear || done) begin
        checks++;
        if (int'(buf_we) + int'(buf_clear) + int'(done) != 1) begin
          errors++;
          $display("FAIL strobe_overlap: we=%0b clr=%0b done=%0b, required one",
                   buf_we, buf_clear, done);
        end
      end
      if (buf_we) begin
        n_we++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr=%0d data=%h, required none",
                   buf_waddr, buf_wdata);
        end else begin
          e  = exp_q.pop_front();
          dd = longint'(buf_wdata) - longint'(e.data);
          if (buf_waddr !== e.addr || dd > e.tol || dd < -e.tol) begin
            errors++;
            $display("FAIL write: got (%0d,%h) required (%0d,%h +/-%0d)",
                     buf_waddr, buf_wdata, e.addr, e.data, e.tol);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push_exp(input int a, input logic [DW-1:0] d, input int tol);
    exp_t e;
    e.addr = IW'(a);
    e.data = d;
    e.tol  = tol;
    exp_q.push_back(e);
  endtask

  task automatic push_basic();
    push_exp(0, 32'h00009999, 0);
    push_exp(1, 32'h00000000, 0);
    push_exp(2, 32'h0000CCCC, 0);
    push_exp(3, 32'h00000000, 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic feed(input logic [DW-1:0] d [4], input bit bp,
                      output int xfers, output int not_ready);
    int i;
    int cyc;
    i = 0;
    cyc = 0;
    xfers = 0;
    not_ready = 0;
    while (i < 4 && cyc < 100) begin
      in_valid = bp ? (cyc % 3 == 0) : 1'b1;
      in_data  = d[i];
      @(negedge clk);
      if (!in_ready) not_ready++;
      if (in_valid && in_ready) begin
        xfers++;
        i++;
      end
      @(posedge clk);
      #1 cyc++;
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_done(input int budget, output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    while (!ok && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (done) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    in_valid = 1'b1;
    in_data  = 32'h00010000;
    @(negedge clk);
    checks++;
    if ({busy, in_ready, buf_we, buf_clear, done, goodness_valid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {busy, in_ready, buf_we, buf_clear, done, goodness_valid});
    end
    checks++;
    if (goodness !== '0 || buf_wdata !== '0 || buf_waddr !== '0) begin
      errors++;
      $display("FAIL reset_data: goodness=%h wdata=%h waddr=%0d required 0",
               goodness, buf_wdata, buf_waddr);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid: busy=%b in_ready=%b required 0 0", busy, in_ready);
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic test_basic();
    int clr0, we0, x, nr, cyc;
    bit ok;
    clr0 = n_clr;
    we0  = n_we;
    push_basic();
    do_start();
    checks++;
    if (n_clr != clr0 + 1) begin
      errors++;
      $display("FAIL basic_clear: got %0d pulses required 1", n_clr - clr0);
    end
    feed(d_basic, 1'b0, x, nr);
    checks++;
    if (x != 4 || in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_collect: xfers=%0d in_ready=%b busy=%b required 4 0 1",
               x, in_ready, busy);
    end
    wait_done(1000, ok, cyc);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_done: got timeout required done pulse");
    end
    checks++;
    if (goodness !== 32'h00190000 || goodness_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_goodness: got %h/%b required 00190000/1",
               goodness, goodness_valid);
    end
    checks++;
    if (n_we - we0 != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_writes: got %0d left %0d required 4 left 0",
               n_we - we0, exp_q.size());
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || goodness !== 32'h00190000) begin
      errors++;
      $display("FAIL basic_idle: busy=%b done=%b goodness=%h required 0 0 00190000",
               busy, done, goodness);
    end
  endtask

  task automatic test_all_negative();
    int x, nr, cyc;
    bit ok;
    for (int i = 0; i < 4; i++) push_exp(i, 32'h0, 0);
    do_start();
    feed(d_neg, 1'b0, x, nr);
    wait_done(1000, ok, cyc);
    checks++;
    if (!ok || cyc > 50) begin
      errors++;
      $display("FAIL neg_latency: ok=%b cycles=%0d required done within 50", ok, cyc);
    end
    checks++;
    if (goodness !== 32'h0 || goodness_valid !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL neg_result: goodness=%h gv=%b left=%0d required 0 1 0",
               goodness, goodness_valid, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int x, nr, cyc;
    bit ok;
    push_basic();
    do_start();
    feed(d_basic, 1'b1, x, nr);
    checks++;
    if (x != 4 || nr != 0) begin
      errors++;
      $display("FAIL bp_collect: xfers=%0d ready_low=%0d required 4 0", x, nr);
    end
    wait_done(1000, ok, cyc);
    checks++;
    if (!ok || goodness !== 32'h00190000 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_result: ok=%b goodness=%h left=%0d required 1 00190000 0",
               ok, goodness, exp_q.size());
    end
  endtask

  task automatic test_start_busy();
    int clr0, we0, x, nr, cyc;
    bit ok;
    clr0 = n_clr;
    we0  = n_we;
    push_basic();
    do_start();
    feed(d_basic, 1'b0, x, nr);
    repeat (50) @(negedge clk);
    @(posedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    checks++;
    if (buf_clear !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_start: clear=%b busy=%b required 0 1", buf_clear, busy);
    end
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(1000, ok, cyc);
    checks++;
    if (!ok || n_clr - clr0 != 1 || n_we - we0 != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL busy_pass: ok=%b clears=%0d writes=%0d required 1 1 4",
               ok, n_clr - clr0, n_we - we0);
    end
    checks++;
    if (goodness !== 32'h00190000) begin
      errors++;
      $display("FAIL busy_goodness: got %h required 00190000", goodness);
    end
  endtask

  task automatic test_reset_mid();
    int we0, we1, x, nr, cyc;
    bit ok;
    we0 = n_we;
    push_basic();
    do_start();
    feed(d_basic, 1'b0, x, nr);
    cyc = 0;
    while (n_we == we0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (n_we != we0 + 1) begin
      errors++;
      $display("FAIL mid_first_write: got %0d writes required 1", n_we - we0);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, in_ready, buf_we, done, goodness_valid} !== 5'b0 ||
        goodness !== '0 || buf_wdata !== '0 || buf_waddr !== '0) begin
      errors++;
      $display("FAIL mid_reset_out: ctrl=%b goodness=%h wdata=%h required 0",
               {busy, in_ready, buf_we, done, goodness_valid}, goodness, buf_wdata);
    end
    exp_q.delete();
    we1 = n_we;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (n_we != we1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_quiet: writes=%0d busy=%b required 0 0", n_we - we1, busy);
    end
    test_basic();
  endtask

  task automatic test_saturation();
    int x, nr, cyc;
    bit ok;
    push_exp(0, 32'h0000B504, 1);
    push_exp(1, 32'h0000B504, 1);
    push_exp(2, 32'h0, 0);
    push_exp(3, 32'h0, 0);
    do_start();
    feed(d_sat, 1'b0, x, nr);
    wait_done(1000, ok, cyc);
    checks++;
    if (!ok || goodness !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL sat_goodness: ok=%b got %h required FFFFFFFF", ok, goodness);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sat_writes: got %0d missing required 0", exp_q.size());
    end
  endtask

  initial begin
    d_basic = '{32'h00030000, 32'hFFFE0000, 32'h00040000, 32'h0};
    d_neg   = '{32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000};
    d_sat   = '{32'h7FFF0000, 32'h7FFF0000, 32'h0, 32'h0};
    test_reset();
    test_basic();
    test_all_negative();
    test_backpressure();
    test_start_busy();
    test_reset_mid();
    test_saturation();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
